// File: rtl/aha_periph_reset_sequencer.sv
// Per-peripheral reset sequencer: round-robin arbitration over level reset requests,
// then a gate -> reset -> release -> ungate sequence with a four-phase acknowledge.
module aha_periph_reset_sequencer #(
  parameter int NUM_PERIPH    = 11,
  parameter int GATE_CYCLES   = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8,
  parameter int IDX_W         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PERIPH-1:0] req_i,
  input  logic [NUM_PERIPH-1:0] clk_gate_en_i,
  output logic [NUM_PERIPH-1:0] ack_o,
  output logic [NUM_PERIPH-1:0] periph_rst_n_o,
  output logic [NUM_PERIPH-1:0] clk_en_o,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      active_idx_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_UNGATE = 3'd4
  } state_t;

  // Loading PARAM-1 gives exactly PARAM cycles in the phase; 2^CNT_W loads all ones.
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PERIPH - 1);
  localparam logic [NUM_PERIPH-1:0] ONE_HOT0 = {{(NUM_PERIPH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [NUM_PERIPH-1:0]   gate_mask_r, gate_mask_nxt_s;
  logic [NUM_PERIPH-1:0]   rst_n_r, rst_n_nxt_s;
  logic [NUM_PERIPH-1:0]   ack_r, ack_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;

  logic [NUM_PERIPH-1:0]   elig_s;
  logic [(2**IDX_W)-1:0]   elig_pad_s;
  logic [IDX_W:0]          sum_s;
  logic [IDX_W-1:0]        cand_s;
  logic                    grant_vld_s;
  logic [IDX_W-1:0]        grant_idx_s;
  logic [NUM_PERIPH-1:0]   grant_oh_s;
  logic [NUM_PERIPH-1:0]   act_oh_s;

  assign elig_s     = req_i & ~ack_r;
  assign grant_oh_s = ONE_HOT0 << grant_idx_s;
  assign act_oh_s   = ONE_HOT0 << idx_r;

  // Round-robin search: first eligible index at or above rr_ptr, wrapping at NUM_PERIPH.
  always_comb begin
    elig_pad_s                   = '0;
    elig_pad_s[NUM_PERIPH-1:0]   = elig_s;
    grant_vld_s                  = 1'b0;
    grant_idx_s                  = '0;
    sum_s                        = '0;
    cand_s                       = '0;
    for (int off = 0; off < NUM_PERIPH; off++) begin
      sum_s  = {1'b0, rr_ptr_r} + (IDX_W+1)'(off);
      sum_s  = (sum_s >= (IDX_W+1)'(NUM_PERIPH)) ? (sum_s - (IDX_W+1)'(NUM_PERIPH)) : sum_s;
      cand_s = sum_s[IDX_W-1:0];
      if (!grant_vld_s && elig_pad_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    gate_mask_nxt_s = gate_mask_r;
    rst_n_nxt_s     = rst_n_r;
    idx_nxt_s       = idx_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    // A dropped request clears its acknowledge regardless of sequencer state.
    ack_nxt_s       = ack_r & req_i;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          idx_nxt_s       = grant_idx_s;
          gate_mask_nxt_s = gate_mask_r | grant_oh_s;
          cnt_nxt_s       = GATE_LD;
          rr_ptr_nxt_s    = (grant_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
          state_nxt_s     = ST_GATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          rst_n_nxt_s = rst_n_r & ~act_oh_s;
          cnt_nxt_s   = HOLD_LD;
          state_nxt_s = ST_HOLD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          rst_n_nxt_s = rst_n_r | act_oh_s;
          cnt_nxt_s   = SETTLE_LD;
          state_nxt_s = ST_SETTLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          gate_mask_nxt_s = gate_mask_r & ~act_oh_s;
          state_nxt_s     = ST_UNGATE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_UNGATE: begin
        // A request withdrawn mid-sequence is sampled low here and never acknowledged.
        ack_nxt_s   = ack_nxt_s | (act_oh_s & req_i);
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        gate_mask_nxt_s = {NUM_PERIPH{1'b0}};
        rst_n_nxt_s     = {NUM_PERIPH{1'b1}};
        cnt_nxt_s       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset to the safe idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      gate_mask_r <= {NUM_PERIPH{1'b0}};
      rst_n_r     <= {NUM_PERIPH{1'b1}};
      ack_r       <= {NUM_PERIPH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      gate_mask_r <= gate_mask_nxt_s;
      rst_n_r     <= rst_n_nxt_s;
      ack_r       <= ack_nxt_s;
      idx_r       <= idx_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
    end
  end

  assign ack_o          = ack_r;
  assign periph_rst_n_o = rst_n_r;
  assign clk_en_o       = clk_gate_en_i & ~gate_mask_r;
  assign busy_o         = (state_r != ST_IDLE);
  assign active_idx_o   = idx_r;

endmodule
